serial_link_phy_tx: RTL and testbench
=====================================

SERIAL_LINK_PHY_TX -- requirements
Module: serial_link_phy_tx

Interface
REQ-001 SHALL have parameter NumLanes, default 8: number of DDR data lanes.
REQ-002 SHALL have parameter MaxClkDiv, default 1024: largest supported clock divider; counter width CW = $clog2(MaxClkDiv)+1.
REQ-003 SHALL have port clk_i  input  1: single clock; all logic is in this domain.
REQ-004 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port clk_enable_i  input  1: allows new words to be accepted.
REQ-006 SHALL have port clk_div_i  input  CW: forwarded-clock period in clk_i cycles; even, 2..MaxClkDiv.
REQ-007 SHALL have port clk_shift_start_i  input  CW: count at which the forwarded clock rises.
REQ-008 SHALL have port clk_shift_end_i  input  CW: count at which the forwarded clock falls; start < end <= clk_div.
REQ-009 SHALL have port data_out_i  input  2*NumLanes: one phy word; low half is sent first, high half second.
REQ-010 SHALL have port data_out_valid_i  input  1: word valid.
REQ-011 SHALL have port data_out_ready_o  output  1: word accepted when valid and ready are both high.
REQ-012 SHALL have port ddr_rcv_clk_o  output  1: forwarded clock.
REQ-013 SHALL have port ddr_o  output  NumLanes: lane data.

Function
REQ-014 SHALL use two states: Idle and Busy.
REQ-015 SHALL hold these registers: data_q, cnt_q, div_q, start_q, end_q.
REQ-016 SHALL drive data_out_ready_o = clk_enable_i & (Idle | (Busy & cnt_q == div_q-1)).
REQ-017 On accept, SHALL load data_q <= data_out_i, cnt_q <= 0, div_q/start_q/end_q <= their config inputs, and state <= Busy.
REQ-018 SHALL sample configuration only at accept; changes mid-word SHALL NOT affect the word in flight.
REQ-019 In Busy without accept, SHALL increment cnt_q each cycle.
REQ-020 In Busy at cnt_q == div_q-1 without accept, SHALL go to Idle with cnt_q <= 0.
REQ-021 In Busy at cnt_q == div_q-1 with accept, SHALL stay Busy, restart at cnt_q = 0 and load the new word (back-to-back, no gap).
REQ-022 SHALL drive ddr_o = data_q[NumLanes-1:0] while Busy and cnt_q < div_q/2.
REQ-023 SHALL drive ddr_o = data_q[2*NumLanes-1:NumLanes] while Busy and cnt_q >= div_q/2.
REQ-024 SHALL drive ddr_o = 0 while Idle.
REQ-025 SHALL drive ddr_rcv_clk_o = Busy & (cnt_q >= start_q) & (cnt_q < end_q).
REQ-026 SHALL hold ddr_rcv_clk_o = 0 while Idle.
REQ-027 SHALL decode ddr_o and ddr_rcv_clk_o from registered state only, with no combinational path from inputs.
REQ-028 Latency: a word accepted in cycle N SHALL appear on ddr_o from cycle N+1 for div_q cycles.
REQ-029 Dropping clk_enable_i low while Busy SHALL let the current word complete, then go Idle; no new accept SHALL occur while it is low.
REQ-030 SHALL use CW-bit unsigned arithmetic for the counter; cnt_q SHALL never exceed div_q-1.
REQ-031 SHALL never let the counter wrap past div_q-1.
REQ-032 SHALL ignore data_out_valid_i while data_out_ready_o is low, and SHALL NOT drop or duplicate words.

Reset
REQ-033 On rst_ni low, SHALL asynchronously force state = Idle and cnt_q, div_q, start_q, end_q, data_q = 0.
REQ-034 During reset, SHALL drive ddr_o = 0, ddr_rcv_clk_o = 0 and data_out_ready_o = 0.
REQ-035 Reset asserted mid-word SHALL abort the word; that word SHALL NOT be retransmitted after reset.

Verification
REQ-036 Single word: NumLanes=8, div=4, start=1, end=3, word 0xA55A accepted in cycle 0 -> ddr_o=0x5A in cycles 1-2 and 0xA5 in cycles 3-4; ddr_rcv_clk_o=1 in cycles 2-3; Idle from cycle 5 with ddr_o=0.
REQ-037 Back-to-back: words 0x1122 and 0x3344 with valid held high and div=2 -> ready high in cycles 0 and 2; ddr_o sequence 22,11,44,33; no gap.
REQ-038 Config change mid-word: change div from 4 to 8 in cycle 2 of a word -> current word still lasts 4 cycles; the next word lasts 8 cycles.
REQ-039 Enable drop: clk_enable_i=0 in cycle 1 of a word with valid held high -> word completes, ready stays 0, outputs return to 0; re-enable -> next word accepted.
REQ-040 Reset mid-word: assert rst_ni low in cycle 2 of a div=8 word -> ddr_o, ddr_rcv_clk_o and ready go to 0 immediately; after release, the next accepted word is sent intact.
REQ-041 Max divider: div=MaxClkDiv with start=0 and end=MaxClkDiv/2 -> exactly MaxClkDiv cycles per word; clock high for the first half.

Source files
------------

// File: rtl/serial_link_phy_tx.sv
// DDR serial-link transmitter: serialises one 2*NumLanes-bit word per
// forwarded-clock period, low half first, with a programmable forwarded clock.
module serial_link_phy_tx #(
   parameter int unsigned NumLanes  = 8,
   parameter int unsigned MaxClkDiv = 1024
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clk_enable_i,
   input  logic [$clog2(MaxClkDiv):0]    clk_div_i,
   input  logic [$clog2(MaxClkDiv):0]    clk_shift_start_i,
   input  logic [$clog2(MaxClkDiv):0]    clk_shift_end_i,
   input  logic [2*NumLanes-1:0]         data_out_i,
   input  logic                          data_out_valid_i,
   output logic                          data_out_ready_o,
   output logic                          ddr_rcv_clk_o,
   output logic [NumLanes-1:0]           ddr_o
);

   localparam int unsigned CW = $clog2(MaxClkDiv) + 1;
   localparam int unsigned DW = 2 * NumLanes;

   typedef enum logic {
      Idle = 1'b0,
      Busy = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   data_q, data_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   div_q, div_d;
   logic [CW-1:0]   start_q, start_d;
   logic [CW-1:0]   end_q, end_d;

   logic            last_c;
   logic            accept_c;
   logic [CW-1:0]   div_m1_c;
   logic [CW-1:0]   half_c;

   assign div_m1_c = div_q - CW'(1);
   assign half_c   = div_q >> 1;
   assign last_c   = (state_q == Busy) && (cnt_q == div_m1_c);

   // Ready is held low during reset; a new word may land on the last count of the current one.
   assign data_out_ready_o = rst_ni & clk_enable_i & ((state_q == Idle) | last_c);
   assign accept_c         = data_out_ready_o & data_out_valid_i;

   // State and word registers; configuration is captured only when a word is accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         data_q  <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         start_q <= '0;
         end_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         start_q <= start_d;
         end_q   <= end_d;
      end
   end

   // Next-state: accept loads a fresh word, otherwise count up to div-1 and drop to Idle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      start_d = start_q;
      end_d   = end_q;
      if (accept_c) begin
         state_d = Busy;
         data_d  = data_out_i;
         cnt_d   = '0;
         div_d   = clk_div_i;
         start_d = clk_shift_start_i;
         end_d   = clk_shift_end_i;
      end else if (state_q == Busy) begin
         if (last_c) begin
            state_d = Idle;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Lane data: low half for the first half-period, high half for the second.
   always_comb begin
      ddr_o = '0;
      if (state_q == Busy) begin
         if (cnt_q < half_c) begin
            ddr_o = data_q[NumLanes-1:0];
         end else begin
            ddr_o = data_q[DW-1:NumLanes];
         end
      end
   end

   // Forwarded clock is high over the captured [start, end) window of the count.
   always_comb begin
      ddr_rcv_clk_o = 1'b0;
      if (state_q == Busy) begin
         ddr_rcv_clk_o = (cnt_q >= start_q) && (cnt_q < end_q);
      end
   end

endmodule

// File: tb/tb_serial_link_phy_tx.sv
// Scoreboard bench for serial_link_phy_tx: per-cycle lane/clock expectations are
// queued at accept time and popped by a monitor on every falling edge.
module tb_serial_link_phy_tx;

   localparam int unsigned NL = 8;
   localparam int unsigned MD = 1024;
   localparam int unsigned CW = 11;

   typedef struct {
      logic [NL-1:0] ddr;
      logic          rclk;
   } exp_t;

   logic            clk_i;
   logic            rst_ni;
   logic            clk_enable_i;
   logic [CW-1:0]   clk_div_i;
   logic [CW-1:0]   clk_shift_start_i;
   logic [CW-1:0]   clk_shift_end_i;
   logic [2*NL-1:0] data_out_i;
   logic            data_out_valid_i;
   logic            data_out_ready_o;
   logic            ddr_rcv_clk_o;
   logic [NL-1:0]   ddr_o;

   exp_t sb[$];
   int   n_checks;
   int   n_fail;

   serial_link_phy_tx #(.NumLanes(NL), .MaxClkDiv(MD)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .clk_enable_i      (clk_enable_i),
      .clk_div_i         (clk_div_i),
      .clk_shift_start_i (clk_shift_start_i),
      .clk_shift_end_i   (clk_shift_end_i),
      .data_out_i        (data_out_i),
      .data_out_valid_i  (data_out_valid_i),
      .data_out_ready_o  (data_out_ready_o),
      .ddr_rcv_clk_o     (ddr_rcv_clk_o),
      .ddr_o             (ddr_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic void check(string name, int unsigned act, int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push_exp(logic [NL-1:0] d, logic c);
      exp_t e;
      e.ddr  = d;
      e.rclk = c;
      sb.push_back(e);
   endfunction

   // Reference waveform of one word: low byte for div/2 cycles, then high byte.
   function automatic void push_word(logic [2*NL-1:0] w, int div, int st, int en);
      logic [NL-1:0] lo, hi;
      lo = w[NL-1:0];
      hi = w[2*NL-1:NL];
      for (int c = 0; c < div; c++) begin
         push_exp((c < div / 2) ? lo : hi, (c >= st) && (c < en));
      end
   endfunction

   // Present a word with its config and wait for the handshake; leaves valid high.
   task automatic send(input logic [2*NL-1:0] w, input int div, input int st, input int en,
                       input bit use_model, input int exp_wait, input string name);
      int waits;
      bit ok;
      data_out_i        = w;
      clk_div_i         = CW'(div);
      clk_shift_start_i = CW'(st);
      clk_shift_end_i   = CW'(en);
      data_out_valid_i  = 1'b1;
      waits = 0;
      ok    = 1'b0;
      while (waits <= 5000) begin
         @(negedge clk_i);
         if (data_out_ready_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         waits++;
      end
      if (!ok) begin
         check({name, "_accept_timeout"}, 0, 1);
         return;
      end
      check({name, "_ready_wait"}, waits, exp_wait);
      @(posedge clk_i);
      #1;
      if (use_model) push_word(w, div, st, en);
   endtask

   task automatic idle_cycles(input int n);
      data_out_valid_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      n_checks          = 0;
      n_fail            = 0;
      rst_ni            = 1'b0;
      clk_enable_i      = 1'b1;
      clk_div_i         = '0;
      clk_shift_start_i = '0;
      clk_shift_end_i   = '0;
      data_out_i        = '0;
      data_out_valid_i  = 1'b0;

      fork
         // Monitor: every falling edge consumes one expectation, or expects an idle link.
         forever begin
            exp_t e;
            @(negedge clk_i);
            if (!rst_ni) begin
               check("rst_ddr_o", ddr_o, 0);
               check("rst_rcv_clk", ddr_rcv_clk_o, 0);
               check("rst_ready", data_out_ready_o, 0);
            end else if (sb.size() > 0) begin
               e = sb.pop_front();
               check("ddr_o", ddr_o, e.ddr);
               check("ddr_rcv_clk_o", ddr_rcv_clk_o, e.rclk);
            end else begin
               check("idle_ddr_o", ddr_o, 0);
               check("idle_rcv_clk", ddr_rcv_clk_o, 0);
            end
         end
      join_none

      #1;
      check("por_ddr_o", ddr_o, 0);
      check("por_ready", data_out_ready_o, 0);
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      idle_cycles(2);

      // Single word 0xA55A, div 4, clock window [1,3).
      send(16'hA55A, 4, 1, 3, 1'b0, 0, "single");
      push_exp(8'h5A, 1'b0);
      push_exp(8'h5A, 1'b1);
      push_exp(8'hA5, 1'b1);
      push_exp(8'hA5, 1'b0);
      idle_cycles(6);

      // Back-to-back at div 2: second accept lands on the first word's last count.
      send(16'h1122, 2, 0, 1, 1'b0, 0, "b2b_first");
      push_exp(8'h22, 1'b1);
      push_exp(8'h11, 1'b0);
      send(16'h3344, 2, 0, 1, 1'b0, 1, "b2b_second");
      push_exp(8'h44, 1'b1);
      push_exp(8'h33, 1'b0);
      idle_cycles(4);

      // Config change from div 4 to 8 in cycle 2 of a word.
      send(16'hBEEF, 4, 1, 3, 1'b1, 0, "cfg_first");
      @(posedge clk_i);
      #1;
      send(16'hC0DE, 8, 2, 6, 1'b1, 2, "cfg_second");
      idle_cycles(10);

      // Enable dropped in cycle 1 with valid still high.
      send(16'h1234, 4, 1, 3, 1'b1, 0, "en_first");
      clk_enable_i = 1'b0;
      data_out_i   = 16'h5678;
      repeat (6) begin
         @(negedge clk_i);
         check("en_low_ready", data_out_ready_o, 0);
      end
      @(posedge clk_i);
      #1;
      clk_enable_i = 1'b1;
      send(16'h5678, 2, 0, 1, 1'b1, 0, "en_resume");
      idle_cycles(4);

      // Reset in cycle 2 of a div-8 word, while lanes and clock are active.
      send(16'h9ABC, 8, 1, 6, 1'b0, 0, "rst_word");
      push_exp(8'hBC, 1'b0);
      data_out_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      sb.delete();
      rst_ni = 1'b0;
      #1;
      check("midrst_ddr_o", ddr_o, 0);
      check("midrst_rcv_clk", ddr_rcv_clk_o, 0);
      check("midrst_ready", data_out_ready_o, 0);
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      idle_cycles(3);
      send(16'h0FF0, 4, 1, 3, 1'b1, 0, "post_rst");
      idle_cycles(8);

      // Largest divider: clock high for the first half of the period.
      send(16'h6996, MD, 0, MD / 2, 1'b1, 0, "maxdiv");
      idle_cycles(MD + 6);

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
